// File: rtl/switch_arb.sv
// switch_arb: two-source round-robin arbiter with burst limiting in front of the
// address-routing switch input port. One beat per cycle is granted and forwarded
// through a single output register stage.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   en                   arbitration enable (no grants while low)
//   clr                  synchronous clear of the beat counters
//   s0_vld/addr/data     source 0 beat in;  s0_rdy out: beat accepted this cycle
//   s1_vld/addr/data     source 1 beat in;  s1_rdy out: beat accepted this cycle
//   vld/addr/data        registered beat to the switch
//   gnt_id               source of the beat currently on vld/addr/data
//   cnt0, cnt1           saturating accepted-beat counters per source
module switch_arb #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  s0_vld,
  input  logic [ADDR_WIDTH-1:0] s0_addr,
  input  logic [DATA_WIDTH-1:0] s0_data,
  output logic                  s0_rdy,
  input  logic                  s1_vld,
  input  logic [ADDR_WIDTH-1:0] s1_addr,
  input  logic [DATA_WIDTH-1:0] s1_data,
  output logic                  s1_rdy,
  output logic                  vld,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  gnt_id,
  output logic [CNT_WIDTH-1:0]  cnt0,
  output logic [CNT_WIDTH-1:0]  cnt1
);

  localparam int unsigned           BurstW   = $clog2(MAX_BURST + 1);
  localparam logic [BurstW-1:0]     BurstMax = BurstW'(MAX_BURST);
  localparam logic [CNT_WIDTH-1:0]  CntMax   = '1;

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

  state_e              state_q;
  logic                rr_ptr_q;
  logic [BurstW-1:0]   burst_cnt_q;
  logic                gnt0, gnt1, xfer, burst_ok;

  // Grant decode. Gated by rstn so neither source sees rdy while in reset.
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    burst_ok = (burst_cnt_q < BurstMax);
    if (rstn && en) begin
      case (state_q)
        StIdle: begin
          if (s0_vld && s1_vld) begin
            gnt0 = ~rr_ptr_q;
            gnt1 = rr_ptr_q;
          end else begin
            gnt0 = s0_vld;
            gnt1 = s1_vld;
          end
        end
        // Owner keeps going until its burst is spent and the other side waits;
        // dropping vld hands over in the same cycle.
        StGnt0: begin
          if (s0_vld && (burst_ok || !s1_vld)) gnt0 = 1'b1;
          else                                 gnt1 = s1_vld;
        end
        StGnt1: begin
          if (s1_vld && (burst_ok || !s0_vld)) gnt1 = 1'b1;
          else                                 gnt0 = s0_vld;
        end
        default: ;
      endcase
    end
  end

  assign s0_rdy = gnt0;
  assign s1_rdy = gnt1;
  assign xfer   = gnt0 | gnt1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      rr_ptr_q    <= 1'b0;
      burst_cnt_q <= '0;
    end else if (!xfer) begin
      // Covers en low too: rr_ptr is left untouched.
      state_q     <= StIdle;
      burst_cnt_q <= '0;
    end else if (gnt0) begin
      state_q     <= StGnt0;
      rr_ptr_q    <= 1'b1;
      if (state_q != StGnt0) burst_cnt_q <= BurstW'(1);
      else if (burst_ok)     burst_cnt_q <= burst_cnt_q + BurstW'(1);
    end else begin
      state_q     <= StGnt1;
      rr_ptr_q    <= 1'b0;
      if (state_q != StGnt1) burst_cnt_q <= BurstW'(1);
      else if (burst_ok)     burst_cnt_q <= burst_cnt_q + BurstW'(1);
    end
  end

  // Output register stage; addr/data/gnt_id hold when no beat is forwarded.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld    <= 1'b0;
      addr   <= '0;
      data   <= '0;
      gnt_id <= 1'b0;
    end else begin
      vld <= xfer;
      if (xfer) begin
        addr   <= gnt1 ? s1_addr : s0_addr;
        data   <= gnt1 ? s1_data : s0_data;
        gnt_id <= gnt1;
      end
    end
  end

  // Beat counters; clr wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (clr) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (gnt0 && (cnt0 != CntMax)) cnt0 <= cnt0 + CNT_WIDTH'(1);
      if (gnt1 && (cnt1 != CntMax)) cnt1 <= cnt1 + CNT_WIDTH'(1);
    end
  end

endmodule
